// File: rtl/reg_status_file.sv
// Architectural register file with per-register rename status (busy + ROB tag).
// Dispatch renames destinations, ROB commit writes values and retires matching renames.
module reg_status_file #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int TAGW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            rn_valid,
  input  logic [4:0]      rn_rd,
  input  logic [TAGW-1:0] rn_tag,
  input  logic [4:0]      rs1_idx,
  input  logic [4:0]      rs2_idx,
  output logic [XLEN-1:0] rs1_data,
  output logic            rs1_ready,
  output logic [TAGW-1:0] rs1_tag,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs2_ready,
  output logic [TAGW-1:0] rs2_tag,
  input  logic            commit_valid,
  input  logic [4:0]      commit_idx,
  input  logic [XLEN-1:0] commit_data,
  input  logic [TAGW-1:0] commit_tag,
  input  logic            flush,
  output logic [5:0]      busy_count
);

  typedef struct packed {
    logic [XLEN-1:0] data;
    logic            ready;
    logic [TAGW-1:0] tag;
  } rd_t;

  logic [XLEN-1:0] regs_q [NREG];
  logic [TAGW-1:0] tag_q  [NREG];
  logic [NREG-1:0] busy_q;

  logic commit_wr;
  logic commit_clr;
  logic rn_wr;

  assign commit_wr  = commit_valid && (commit_idx != 5'd0);
  assign commit_clr = commit_wr && busy_q[commit_idx] && (tag_q[commit_idx] == commit_tag);
  assign rn_wr      = rn_valid && (rn_rd != 5'd0);

  // Rename is applied after commit-clear so it wins on the same register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
        tag_q[i]  <= '0;
      end
      busy_q <= '0;
    end else begin
      if (commit_wr)
        regs_q[commit_idx] <= commit_data;
      if (flush) begin
        busy_q <= '0;
      end else begin
        if (commit_clr)
          busy_q[commit_idx] <= 1'b0;
        if (rn_wr) begin
          busy_q[rn_rd] <= 1'b1;
          tag_q[rn_rd]  <= rn_tag;
        end
      end
    end
  end

  function automatic rd_t read_port(input logic [4:0] idx);
    rd_t r;
    r.data  = regs_q[idx];
    r.ready = 1'b0;
    r.tag   = tag_q[idx];
    if (idx == 5'd0) begin
      r.data  = '0;
      r.ready = 1'b1;
      r.tag   = '0;
    end else if (!busy_q[idx]) begin
      r.ready = 1'b1;
    end else if (commit_valid && (commit_idx == idx) && (commit_tag == tag_q[idx])) begin
      // Producer is committing right now: forward its value.
      r.data  = commit_data;
      r.ready = 1'b1;
    end
    return r;
  endfunction

  rd_t rd1;
  rd_t rd2;

  always_comb begin
    rd1 = read_port(rs1_idx);
    rd2 = read_port(rs2_idx);
  end

  assign rs1_data  = rd1.data;
  assign rs1_ready = rd1.ready;
  assign rs1_tag   = rd1.tag;
  assign rs2_data  = rd2.data;
  assign rs2_ready = rd2.ready;
  assign rs2_tag   = rd2.tag;

  always_comb begin
    busy_count = '0;
    for (int i = 0; i < NREG; i++)
      busy_count = busy_count + 6'(busy_q[i]);
  end

endmodule

// File: tb/tb_reg_status_file.sv
// Directed bench for reg_status_file: rename, commit, bypass, stale commit, flush, x0, reset.
module tb_reg_status_file;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rn_valid;
  logic [4:0]  rn_rd;
  logic [2:0]  rn_tag;
  logic [4:0]  rs1_idx;
  logic [4:0]  rs2_idx;
  logic [31:0] rs1_data;
  logic        rs1_ready;
  logic [2:0]  rs1_tag;
  logic [31:0] rs2_data;
  logic        rs2_ready;
  logic [2:0]  rs2_tag;
  logic        commit_valid;
  logic [4:0]  commit_idx;
  logic [31:0] commit_data;
  logic [2:0]  commit_tag;
  logic        flush;
  logic [5:0]  busy_count;

  int total = 0;
  int bad   = 0;

  reg_status_file #(.XLEN(32), .NREG(32), .TAGW(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rn_valid     (rn_valid),
    .rn_rd        (rn_rd),
    .rn_tag       (rn_tag),
    .rs1_idx      (rs1_idx),
    .rs2_idx      (rs2_idx),
    .rs1_data     (rs1_data),
    .rs1_ready    (rs1_ready),
    .rs1_tag      (rs1_tag),
    .rs2_data     (rs2_data),
    .rs2_ready    (rs2_ready),
    .rs2_tag      (rs2_tag),
    .commit_valid (commit_valid),
    .commit_idx   (commit_idx),
    .commit_data  (commit_data),
    .commit_tag   (commit_tag),
    .flush        (flush),
    .busy_count   (busy_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rn_valid     = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic rename(input logic [4:0] rd, input logic [2:0] t);
    rn_valid = 1'b1;
    rn_rd    = rd;
    rn_tag   = t;
  endtask

  task automatic commit(input logic [4:0] rd, input logic [2:0] t, input logic [31:0] d);
    commit_valid = 1'b1;
    commit_idx   = rd;
    commit_tag   = t;
    commit_data  = d;
  endtask

  initial begin
    rst_n = 1'b0;
    rn_rd = '0; rn_tag = '0; rs1_idx = '0; rs2_idx = '0;
    commit_idx = '0; commit_tag = '0; commit_data = '0;
    idle();
    // Rename asserted during reset must be ignored.
    rename(5'd5, 3'd4);
    tick();
    tick();
    idle();
    rst_n = 1'b1;

    rs1_idx = 5'd5; rs2_idx = 5'd0; #1;
    check("rst_x5_ready", 32'(rs1_ready), 1);
    check("rst_x5_data",  rs1_data, 0);
    check("rst_x5_tag",   32'(rs1_tag), 0);
    check("rst_x0_ready", 32'(rs2_ready), 1);
    check("rst_x0_data",  rs2_data, 0);
    check("rst_count",    32'(busy_count), 0);

    // Rename x3 -> tag 2, then bypass commit.
    rename(5'd3, 3'd2);
    tick();
    idle();
    rs1_idx = 5'd3; rs2_idx = 5'd3; #1;
    check("x3_busy_ready", 32'(rs1_ready), 0);
    check("x3_busy_tag",   32'(rs1_tag), 2);
    check("x3_count",      32'(busy_count), 1);
    commit(5'd3, 3'd2, 32'hDEADBEEF); #1;
    check("x3_byp_ready",  32'(rs1_ready), 1);
    check("x3_byp_data",   rs1_data, 32'hDEADBEEF);
    check("x3_byp_p2",     rs2_data, 32'hDEADBEEF);
    tick();
    idle(); #1;
    check("x3_reg_ready",  32'(rs1_ready), 1);
    check("x3_reg_data",   rs1_data, 32'hDEADBEEF);
    check("x3_count0",     32'(busy_count), 0);

    // Re-rename x4; stale commit writes data but keeps rename.
    rename(5'd4, 3'd1);
    tick();
    rename(5'd4, 3'd5);
    tick();
    idle();
    rs1_idx = 5'd4;
    commit(5'd4, 3'd1, 32'h11); #1;
    check("x4_stale_nobyp", 32'(rs1_ready), 0);
    check("x4_stale_tag",   32'(rs1_tag), 5);
    tick();
    idle(); #1;
    check("x4_after_ready", 32'(rs1_ready), 0);
    check("x4_after_tag",   32'(rs1_tag), 5);
    check("x4_after_data",  rs1_data, 32'h11);
    check("x4_after_count", 32'(busy_count), 1);
    commit(5'd4, 3'd5, 32'h22);
    tick();
    idle(); #1;
    check("x4_final_ready", 32'(rs1_ready), 1);
    check("x4_final_data",  rs1_data, 32'h22);
    check("x4_final_count", 32'(busy_count), 0);

    // Same-cycle rename and commit to x7: rename wins, data written.
    rename(5'd7, 3'd6);
    commit(5'd7, 3'd6, 32'h33);
    tick();
    idle();
    rs1_idx = 5'd7; #1;
    check("x7_ready", 32'(rs1_ready), 0);
    check("x7_tag",   32'(rs1_tag), 6);
    check("x7_data",  rs1_data, 32'h33);
    check("x7_count", 32'(busy_count), 1);
    commit(5'd7, 3'd6, 32'h33);
    tick();
    idle(); #1;
    check("x7_clear_count", 32'(busy_count), 0);

    // Flush overrides rename and commit-clear; commit data still lands.
    rename(5'd1, 3'd0); tick();
    rename(5'd2, 3'd1); tick();
    rename(5'd9, 3'd3); tick();
    idle(); #1;
    check("three_busy", 32'(busy_count), 3);
    flush = 1'b1;
    rename(5'd10, 3'd4);
    commit(5'd9, 3'd3, 32'h99);
    tick();
    idle();
    rs1_idx = 5'd10; rs2_idx = 5'd9; #1;
    check("flush_count",   32'(busy_count), 0);
    check("flush_x10_rdy", 32'(rs1_ready), 1);
    check("flush_x10_dat", rs1_data, 0);
    check("flush_x9_rdy",  32'(rs2_ready), 1);
    check("flush_x9_dat",  rs2_data, 32'h99);
    rs1_idx = 5'd4; rs2_idx = 5'd1; #1;
    check("flush_x4_dat",  rs1_data, 32'h22);
    check("flush_x1_rdy",  32'(rs2_ready), 1);

    // x0 ignores rename and commit, even while a commit is in flight.
    rename(5'd0, 3'd7);
    commit(5'd0, 3'd7, 32'h55);
    rs1_idx = 5'd0; #1;
    check("x0_live_data", rs1_data, 0);
    tick();
    idle(); #1;
    check("x0_ready", 32'(rs1_ready), 1);
    check("x0_data",  rs1_data, 0);
    check("x0_tag",   32'(rs1_tag), 0);
    check("x0_count", 32'(busy_count), 0);

    // Reset mid-operation with x3 busy.
    rename(5'd3, 3'd2);
    tick();
    idle();
    rs1_idx = 5'd3; #1;
    check("pre_rst_busy", 32'(busy_count), 1);
    rst_n = 1'b0;
    rename(5'd6, 3'd1);
    tick();
    idle();
    rst_n = 1'b1;
    rs2_idx = 5'd4; #1;
    check("rst2_x3_ready", 32'(rs1_ready), 1);
    check("rst2_x3_data",  rs1_data, 0);
    check("rst2_x4_data",  rs2_data, 0);
    check("rst2_count",    32'(busy_count), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
